aes_inv_cipher_iter: RTL and testbench

//  Iterative, clocked AES inverse cipher (FIPS-197 InvCipher): one round per clock instead of a fully unrolled combinational datapath.

---
 rtl/aes_inv_cipher_iter.sv | 192 +++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher: one InvCipher round per clock, valid/ready on both sides.
// Defining AES_INV_ABORT_EN adds an abort input that drops the in-flight block.
module aes_inv_cipher_iter #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef AES_INV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:NK*32-1] in_key,
    input  logic [0:127]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_data,
    output logic             busy
);

    localparam int KW = NK * 32;
    localparam int NW = 4 * (NR + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    state_t           state, state_nxt;
    logic [0:127]     data_q, st, rk;
    logic [0:KW-1]    key_q;
    logic [3:0]       rnd, rk_idx;
    logic [0:32*NW-1] w;
    logic             abort_hit;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
        return o;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        for (int b = 0; b < 16; b++) o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c    +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[32*c+8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Full key schedule, combinational from the registered key; round key r is w[128*r +: 128].
    function automatic logic [0:32*NW-1] key_expand(input logic [0:KW-1] key);
        logic [31:0]      wd [NW];
        logic [31:0]      t;
        logic [7:0]       rc;
        logic [0:32*NW-1] flat;
        rc = 8'h01;
        for (int i = 0; i < NK; i++) wd[i] = key[32*i +: 32];
        for (int i = NK; i < NW; i++) begin
            t = wd[i-1];
            if (i % NK == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-NK] ^ t;
        end
        for (int i = 0; i < NW; i++) flat[32*i +: 32] = wd[i];
        return flat;
    endfunction

`ifdef AES_INV_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // LOAD uses the last round key; ROUND and FINAL use rk(rnd), and rnd has reached 0 by FINAL.
    assign rk_idx = (state == LOAD) ? 4'(NR) : rnd;
    assign w      = key_expand(key_q);
    assign rk     = w[128*int'(rk_idx) +: 128];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = ROUND;
            ROUND:   if (rnd == 4'd1) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            key_q    <= '0;
            st       <= '0;
            rnd      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    data_q <= in_data;
                    key_q  <= in_key;
                end
                LOAD: begin
                    st  <= data_q ^ rk;
                    rnd <= 4'(NR - 1);
                end
                ROUND: begin
                    st  <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(st)) ^ rk);
                    rnd <= rnd - 4'd1;
                end
                FINAL: if (!abort_hit) out_data <= inv_sub_bytes(inv_shift_rows(st)) ^ rk;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: NK=4/6/8 instances, FIPS-197 vectors plus random blocks
// encrypted by a forward-cipher model built from table-driven byte arithmetic.
module tb_aes_inv_cipher_iter;

    localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:255] K4  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] K6  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [0:255] K8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv, out_ready, abort;
    logic [0:255] key;
    logic [0:127] din;
    int           sel;
    int           checks = 0;
    int           failures = 0;

    logic         in_valid4, in_valid6, in_valid8;
    logic         in_ready4, in_ready6, in_ready8;
    logic         out_valid4, out_valid6, out_valid8;
    logic         busy4, busy6, busy8;
    logic [0:127] out_data4, out_data6, out_data8;
    logic         obs_ready, obs_valid, obs_busy;
    logic [0:127] obs_data;

    logic [7:0]   sbox_t [256];

    always #5 clk = ~clk;

    assign in_valid4 = iv && (sel == 0);
    assign in_valid6 = iv && (sel == 1);
    assign in_valid8 = iv && (sel == 2);

    always_comb begin
        obs_ready = in_ready4;
        obs_valid = out_valid4;
        obs_busy  = busy4;
        obs_data  = out_data4;
        if (sel == 1) begin
            obs_ready = in_ready6;
            obs_valid = out_valid6;
            obs_busy  = busy6;
            obs_data  = out_data6;
        end else if (sel == 2) begin
            obs_ready = in_ready8;
            obs_valid = out_valid8;
            obs_busy  = busy8;
            obs_data  = out_data8;
        end
    end

    aes_inv_cipher_iter #(.NK(4), .NR(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid4), .in_ready(in_ready4), .in_key(key[0:127]), .in_data(din),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
    );

    aes_inv_cipher_iter #(.NK(6), .NR(12)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid6), .in_ready(in_ready6), .in_key(key[0:191]), .in_data(din),
        .out_valid(out_valid6), .out_ready(out_ready), .out_data(out_data6), .busy(busy6)
    );

    aes_inv_cipher_iter #(.NK(8), .NR(14)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid8), .in_ready(in_ready8), .in_key(key), .in_data(din),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model: forward AES cipher ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:127] model_encrypt(input logic [0:255] k, input int nk, input logic [0:127] pt);
        logic [7:0]   w [240];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   u [4];
        logic [7:0]   rc;
        logic [0:127] o;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*nk; i++) w[i] = k[8*i +: 8];
        for (int i = nk; i < 4*(nr+1); i++) begin
            for (int j = 0; j < 4; j++) a[j] = w[4*(i-1)+j];
            if (i % nk == 0) begin
                u[0] = sbox_t[a[1]] ^ rc;
                u[1] = sbox_t[a[2]];
                u[2] = sbox_t[a[3]];
                u[3] = sbox_t[a[0]];
                rc   = gm(rc, 8'h02);
            end else begin
                for (int j = 0; j < 4; j++) u[j] = (nk > 6 && i % nk == 4) ? sbox_t[a[j]] : a[j];
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-nk)+j] ^ u[j];
        end
        for (int b = 0; b < 16; b++) s[b] = pt[8*b +: 8] ^ w[b];
        for (int r = 1; r <= nr; r++) begin
            for (int b = 0; b < 16; b++) t[b] = sbox_t[s[b]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    s[4*c]   = gm(a[0], 8'h02) ^ gm(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gm(a[1], 8'h02) ^ gm(a[2], 8'h03) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gm(a[2], 8'h02) ^ gm(a[3], 8'h03);
                    s[4*c+3] = gm(a[0], 8'h03) ^ a[1] ^ a[2] ^ gm(a[3], 8'h02);
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[16*r+b];
        end
        for (int b = 0; b < 16; b++) o[8*b +: 8] = s[b];
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_block(input int s, input logic [0:255] k, input logic [0:127] ct, input string tag);
        int guard;
        guard = 0;
        sel = s;
        #1;
        while (!obs_ready && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        key = k;
        din = ct;
        iv  = 1'b1;
        @(posedge clk); #1;
        iv  = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        din = {$urandom, $urandom, $urandom, $urandom};
        check({tag, "_accept"}, {obs_busy, obs_ready}, 2'b10);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!obs_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic watch_no_valid(input string tag);
        int seen;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (obs_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic run_and_check(input int s, input logic [0:255] k, input logic [0:127] ct,
                                 input logic [0:127] pt, input logic early, input string tag);
        int lat;
        out_ready = early;
        start_block(s, k, ct, tag);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 11 + 2*s);
        check({tag, "_data"}, obs_data, pt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_after"}, {obs_valid, obs_ready, obs_busy}, 3'b010);
    endtask

    initial begin
        logic [0:255] kr;
        logic [0:127] ptr, ctr;
        int           lat;

        rst_n = 1'b0; iv = 1'b0; out_ready = 1'b0; abort = 1'b0;
        key = '0; din = '0; sel = 0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check("reset_outputs", {obs_ready, obs_valid, obs_busy, obs_data}, {3'b100, 128'h0});
        end

        check("model_kat128", model_encrypt(K4, 4, PT), CT4);
        check("model_kat192", model_encrypt(K6, 6, PT), CT6);
        check("model_kat256", model_encrypt(K8, 8, PT), CT8);

        run_and_check(0, K4, CT4, PT, 1'b0, "kat128");
        run_and_check(1, K6, CT6, PT, 1'b0, "kat192");
        run_and_check(2, K8, CT8, PT, 1'b1, "kat256");

        // Back-pressure: result must hold for 20 clocks.
        out_ready = 1'b0;
        start_block(0, K4, CT4, "bp");
        wait_valid(lat);
        check("bp_lat", lat, 11);
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", {obs_valid, obs_ready, obs_busy, obs_data}, {3'b101, PT});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {obs_valid, obs_ready, obs_busy}, 3'b010);

        // Second block offered while busy: ignored, then accepted once in_ready returns.
        kr  = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        ptr = {$urandom, $urandom, $urandom, $urandom};
        ctr = model_encrypt(kr, 4, ptr);
        start_block(0, K4, CT4, "ign");
        key = kr; din = ctr; iv = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("ign_ready_low", obs_ready, 1'b0);
        wait_valid(lat);
        check("ign_first_lat", lat + 3, 11);
        check("ign_first_data", obs_data, PT);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ign_idle", {obs_ready, obs_valid}, 2'b10);
        @(posedge clk); #1;
        iv = 1'b0;
        check("ign_second_accept", {obs_busy, obs_ready}, 2'b10);
        wait_valid(lat);
        check("ign_second_lat", lat, 11);
        check("ign_second_data", obs_data, ptr);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset mid-round (rnd=5): outputs clear at once, block is lost.
        start_block(0, K4, CT4, "rst");
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_async", {obs_ready, obs_valid, obs_busy, obs_data}, {3'b100, 128'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check("rst_release", {obs_ready, obs_busy}, 2'b10);
        watch_no_valid("rst_no_valid");
        run_and_check(0, K4, CT4, PT, 1'b0, "rst_next");

`ifdef AES_INV_ABORT_EN
        start_block(0, K4, CT4, "abt");
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abt_idle", {obs_ready, obs_busy, obs_valid}, 3'b100);
        watch_no_valid("abt_no_valid");
        run_and_check(0, K4, CT4, PT, 1'b0, "abt_next");
`endif

        for (int n = 0; n < 9; n++) begin
            kr  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ptr = {$urandom, $urandom, $urandom, $urandom};
            ctr = model_encrypt(kr, 4 + 2*(n % 3), ptr);
            run_and_check(n % 3, kr, ctr, ptr, (n % 2) == 1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
